// File: rtl/exu_alu_pkg.sv
`default_nettype none
// =============================================================================
// exu_alu_pkg : opcodes, FSM state encoding and default width for the EXU ALU
// Rev 1.0
// =============================================================================
package exu_alu_pkg;

   localparam int DEFAULT_XLEN = 32;

   localparam int ALU_OP_W = 4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_OP_XOR   = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLT   = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_OP_MVOP2 = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SLL   = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SRL   = 4'd9;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SRA   = 4'd10;

   localparam int ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
   localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

   function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/exu_alu_shifter.sv
`default_nettype none
// =============================================================================
// exu_alu_shifter : iterative shifter, up to SHIFT_STEP bit positions per cycle
// Rev 1.0
// =============================================================================
module exu_alu_shifter #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [XLEN-1:0]          data_in,
   input  logic [$clog2(XLEN)-1:0]  shamt,
   input  logic                     right,
   input  logic                     arith,
   output logic                     busy,
   output logic                     done,
   output logic [XLEN-1:0]          result
);

   localparam int RW = $clog2(XLEN) + 1;
   localparam logic [RW-1:0] STEP_AMT = RW'(SHIFT_STEP);

   logic [XLEN-1:0] r_data;
   logic [RW-1:0]   r_rem;
   logic            r_right;
   logic            r_arith;

   logic [RW-1:0]   w_amt;
   logic [XLEN-1:0] w_next;

   always_comb begin
      w_amt = (r_rem > STEP_AMT) ? STEP_AMT : r_rem;
      if (!r_right) begin
         w_next = r_data << w_amt;
      end else if (r_arith) begin
         w_next = $signed(r_data) >>> w_amt;
      end else begin
         w_next = r_data >> w_amt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_rem   <= '0;
         r_right <= 1'b0;
         r_arith <= 1'b0;
      end else if (start) begin
         r_data  <= data_in;
         r_rem   <= {1'b0, shamt};
         r_right <= right;
         r_arith <= arith;
      end else if (busy) begin
         r_data  <= w_next;
         r_rem   <= r_rem - w_amt;
      end
   end

   // done flags the final step cycle so the caller can leave SHIFT on time
   assign busy   = (r_rem != '0);
   assign done   = busy && (r_rem <= STEP_AMT);
   assign result = r_data;

endmodule
`default_nettype wire

// File: rtl/exu_alu_dpath_pipe.sv
`default_nettype none
// =============================================================================
// exu_alu_dpath_pipe : arbitrated RV integer ALU with iterative shifter
// Rev 1.0
// =============================================================================
module exu_alu_dpath_pipe
   import exu_alu_pkg::*;
#(
   parameter int XLEN       = DEFAULT_XLEN,
   parameter int NREQ       = 3,
   parameter int SHIFT_STEP = 8,
   parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*ALU_OP_W-1:0]   req_op,
   input  logic [NREQ*XLEN-1:0]       req_op1,
   input  logic [NREQ*XLEN-1:0]       req_op2,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [XLEN-1:0]            rsp_res,
   output logic [IDW-1:0]             rsp_id
);

   localparam int SHW = $clog2(XLEN);

   logic [ST_W-1:0]     r_state;
   logic [ST_W-1:0]     w_next_state;

   logic [NREQ-1:0]     w_grant;
   logic [IDW-1:0]      w_gidx;
   logic                w_any;
   logic [ALU_OP_W-1:0] w_op;
   logic [XLEN-1:0]     w_op1;
   logic [XLEN-1:0]     w_op2;

   logic                w_can_accept;
   logic                w_accept;
   logic                w_slot_free;
   logic                w_sh_start;
   logic                w_load_alu;
   logic                w_load_sh;
   logic [SHW-1:0]      w_shamt;

   logic                w_sub;
   logic [XLEN:0]       w_ext_a;
   logic [XLEN:0]       w_ext_b;
   logic [XLEN:0]       w_add_b;
   logic [XLEN:0]       w_sum;
   logic [XLEN-1:0]     w_alu_res;

   logic                w_sh_busy;
   logic                w_sh_done;
   logic [XLEN-1:0]     w_sh_res;

   logic [IDW-1:0]      r_sh_id;
   logic                r_rsp_valid;
   logic [XLEN-1:0]     r_rsp_res;
   logic [IDW-1:0]      r_rsp_id;

   // Fixed priority: the lowest valid index wins and its fields are selected
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_any   = 1'b0;
      w_op    = '0;
      w_op1   = '0;
      w_op2   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && !w_any) begin
            w_any      = 1'b1;
            w_grant[i] = 1'b1;
            w_gidx     = IDW'(i);
            w_op       = req_op[i*ALU_OP_W +: ALU_OP_W];
            w_op1      = req_op1[i*XLEN +: XLEN];
            w_op2      = req_op2[i*XLEN +: XLEN];
         end
      end
   end

   assign w_shamt = w_op2[SHW-1:0];

   // One XLEN+1 adder serves ADD/SUB and both compares via its top bit
   always_comb begin
      w_sub     = (w_op == ALU_OP_SUB) || (w_op == ALU_OP_SLT) || (w_op == ALU_OP_SLTU);
      w_ext_a   = {(w_op != ALU_OP_SLTU) & w_op1[XLEN-1], w_op1};
      w_ext_b   = {(w_op != ALU_OP_SLTU) & w_op2[XLEN-1], w_op2};
      w_add_b   = w_sub ? ~w_ext_b : w_ext_b;
      w_sum     = w_ext_a + w_add_b + {{XLEN{1'b0}}, w_sub};
      w_alu_res = '0;
      case (w_op)
         ALU_OP_ADD, ALU_OP_SUB:   w_alu_res = w_sum[XLEN-1:0];
         ALU_OP_XOR:               w_alu_res = w_op1 ^ w_op2;
         ALU_OP_OR:                w_alu_res = w_op1 | w_op2;
         ALU_OP_AND:               w_alu_res = w_op1 & w_op2;
         ALU_OP_SLT, ALU_OP_SLTU:  w_alu_res = {{(XLEN-1){1'b0}}, w_sum[XLEN]};
         ALU_OP_MVOP2:             w_alu_res = w_op2;
         ALU_OP_SLL, ALU_OP_SRL,
         ALU_OP_SRA:               w_alu_res = w_op1;
         default:                  w_alu_res = '0;
      endcase
   end

   exu_alu_shifter #(
      .XLEN       (XLEN),
      .SHIFT_STEP (SHIFT_STEP)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (w_sh_start),
      .data_in (w_op1),
      .shamt   (w_shamt),
      .right   (w_op != ALU_OP_SLL),
      .arith   (w_op == ALU_OP_SRA),
      .busy    (w_sh_busy),
      .done    (w_sh_done),
      .result  (w_sh_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_sh_start) w_next_state = ST_SHIFT;
         ST_SHIFT: if (w_sh_done || !w_sh_busy) w_next_state = ST_DONE;
         ST_DONE:  if (w_slot_free) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_slot_free  = !r_rsp_valid || rsp_ready;
      w_can_accept = (r_state == ST_IDLE) && w_slot_free;
      w_accept     = w_can_accept && w_any && rst_n;
      w_sh_start   = w_accept && is_shift_op(w_op) && (w_shamt != '0);
      w_load_alu   = w_accept && !w_sh_start;
      w_load_sh    = (r_state == ST_DONE) && w_slot_free;
   end

   // Gated by rst_n so no grant is visible while reset is held
   assign req_ready = w_grant & {NREQ{w_can_accept & rst_n}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_id <= '0;
      end else if (w_sh_start) begin
         r_sh_id <= w_gidx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_res   <= '0;
         r_rsp_id    <= '0;
      end else if (w_load_alu) begin
         r_rsp_valid <= 1'b1;
         r_rsp_res   <= w_alu_res;
         r_rsp_id    <= w_gidx;
      end else if (w_load_sh) begin
         r_rsp_valid <= 1'b1;
         r_rsp_res   <= w_sh_res;
         r_rsp_id    <= r_sh_id;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_res   = r_rsp_res;
   assign rsp_id    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_exu_alu_dpath_pipe.sv
`default_nettype none
// =============================================================================
// tb_exu_alu_dpath_pipe : directed scoreboard bench for exu_alu_dpath_pipe
// Rev 1.0
// =============================================================================
module tb_exu_alu_dpath_pipe;
   import exu_alu_pkg::*;

   localparam int XLEN       = 32;
   localparam int NREQ       = 3;
   localparam int SHIFT_STEP = 8;
   localparam int IDW        = 2;

   typedef struct {
      logic [XLEN-1:0] res;
      logic [IDW-1:0]  id;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ*ALU_OP_W-1:0] req_op;
   logic [NREQ*XLEN-1:0]     req_op1;
   logic [NREQ*XLEN-1:0]     req_op2;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [XLEN-1:0]          rsp_res;
   logic [IDW-1:0]           rsp_id;

   exu_alu_dpath_pipe #(
      .XLEN       (XLEN),
      .NREQ       (NREQ),
      .SHIFT_STEP (SHIFT_STEP),
      .IDW        (IDW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_op1   (req_op1),
      .req_op2   (req_op2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_res   (rsp_res),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: compare each handshaked response with the oldest expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         check("rsp_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("sb_res", 64'(rsp_res), 64'(mon_e.res));
            check("sb_id", 64'(rsp_id), 64'(mon_e.id));
         end
      end
   end

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op[i*ALU_OP_W +: ALU_OP_W] = op;
      req_op1[i*XLEN +: XLEN]        = a;
      req_op2[i*XLEN +: XLEN]        = b;
      req_valid[i]                   = 1'b1;
   endtask

   task automatic expect_rsp(input logic [31:0] res, input int id);
      exp_t e;
      e.res = res;
      e.id  = IDW'(id);
      sb.push_back(e);
   endtask

   // Advance one clock; requests granted at that edge are withdrawn
   task automatic cycle();
      logic [NREQ-1:0] acc;
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
   endtask

   // Drive one request and return #1 after the edge that accepted it (T+1)
   task automatic send(input int i, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit track);
      logic got;
      set_req(i, op, a, b);
      if (track) expect_rsp(exp, i);
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         got = req_ready[i];
         @(posedge clk);
         #1;
      end
      if (got) req_valid[i] = 1'b0;
      check("accept", 64'(got), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      req_op    = '0;
      req_op1   = '0;
      req_op2   = '0;
      repeat (2) @(posedge clk);
      #1;
      set_req(0, ALU_OP_ADD, 32'd1, 32'd1);
      set_req(1, ALU_OP_ADD, 32'd1, 32'd1);
      #1;
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_res", 64'(rsp_res), 64'd0);
      check("reset_rsp_id", 64'(rsp_id), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();

      // ADD wrap and SLT issued together: requestor 1 wins, requestor 2 follows
      set_req(1, ALU_OP_ADD, 32'hFFFF_FFFF, 32'h1);
      set_req(2, ALU_OP_SLT, 32'h8000_0000, 32'h1);
      expect_rsp(32'h0, 1);
      expect_rsp(32'h1, 2);
      #1;
      check("prio_ready", 64'(req_ready), 64'b010);
      cycle();
      check("add_valid", 64'(rsp_valid), 64'd1);
      check("add_res", 64'(rsp_res), 64'h0);
      check("add_id", 64'(rsp_id), 64'd1);
      #1;
      check("retry_ready", 64'(req_ready), 64'b100);
      cycle();
      check("slt_res", 64'(rsp_res), 64'h1);
      check("slt_id", 64'(rsp_id), 64'd2);
      cycle();
      check("drain_valid", 64'(rsp_valid), 64'd0);

      send(0, ALU_OP_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b1);
      check("sltu_res", 64'(rsp_res), 64'h1);
      send(0, ALU_OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1);
      check("sub_res", 64'(rsp_res), 64'hFFFF_FFFF);
      cycle();

      // SRA by 31 with step 8: four shift cycles, DONE, result at T+6
      send(0, ALU_OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b1);
      set_req(2, ALU_OP_ADD, 32'd10, 32'd20);
      expect_rsp(32'd30, 2);
      for (int c = 1; c <= 5; c++) begin
         #1;
         check("sra_wait_valid", 64'(rsp_valid), 64'd0);
         check("sra_wait_ready", 64'(req_ready), 64'd0);
         cycle();
      end
      check("sra_valid_t6", 64'(rsp_valid), 64'd1);
      check("sra_res", 64'(rsp_res), 64'hFFFF_FFFF);
      cycle();
      check("post_shift_add", 64'(rsp_res), 64'd30);
      cycle();

      // Upper shamt bits ignored: 0x24 shifts by 4, a single shift cycle
      send(1, ALU_OP_SRL, 32'hF000_0000, 32'h24, 32'h0F00_0000, 1'b1);
      check("srl_t1_valid", 64'(rsp_valid), 64'd0);
      cycle();
      check("srl_t2_valid", 64'(rsp_valid), 64'd0);
      cycle();
      check("srl_t3_valid", 64'(rsp_valid), 64'd1);
      check("srl_res", 64'(rsp_res), 64'h0F00_0000);
      cycle();

      send(1, ALU_OP_SLL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1);
      check("sll0_valid", 64'(rsp_valid), 64'd1);
      check("sll0_res", 64'(rsp_res), 64'h1234_5678);
      cycle();

      // Backpressure with three queued requests
      rsp_ready = 1'b0;
      set_req(0, ALU_OP_ADD, 32'd1, 32'd2);
      set_req(1, ALU_OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000);
      set_req(2, ALU_OP_MVOP2, 32'h1, 32'hDEAD_BEEF);
      expect_rsp(32'd3, 0);
      expect_rsp(32'h5A5A_A5A5, 1);
      expect_rsp(32'hDEAD_BEEF, 2);
      cycle();
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_ready", 64'(req_ready), 64'd0);
         check("bp_valid", 64'(rsp_valid), 64'd1);
         check("bp_res", 64'(rsp_res), 64'd3);
         cycle();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(req_ready), 64'b010);
      cycle();
      check("bp_id1", 64'(rsp_id), 64'd1);
      check("bp_res1", 64'(rsp_res), 64'h5A5A_A5A5);
      cycle();
      check("bp_id2", 64'(rsp_id), 64'd2);
      check("bp_res2", 64'(rsp_res), 64'hDEAD_BEEF);
      cycle();
      check("bp_drained", 64'(rsp_valid), 64'd0);

      // Held result discarded by asynchronous reset
      rsp_ready = 1'b0;
      send(0, ALU_OP_ADD, 32'd7, 32'd1, 32'd8, 1'b0);
      check("held_valid", 64'(rsp_valid), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(rsp_valid), 64'd0);
      check("async_rst_res", 64'(rsp_res), 64'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      // Reset in the middle of a shift
      send(0, ALU_OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 1'b0);
      cycle();
      #3;
      rst_n = 1'b0;
      set_req(1, ALU_OP_ADD, 32'd4, 32'd4);
      #1;
      check("midshift_rst_valid", 64'(rsp_valid), 64'd0);
      check("midshift_rst_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cycle();
         check("shift_discarded", 64'(rsp_valid), 64'd0);
      end
      send(0, ALU_OP_ADD, 32'd2, 32'd3, 32'd5, 1'b1);
      check("post_rst_valid", 64'(rsp_valid), 64'd1);
      check("post_rst_res", 64'(rsp_res), 64'd5);

      // Illegal opcode yields zero and the next request proceeds normally
      send(1, 4'hF, 32'h1234, 32'h5678, 32'h0, 1'b1);
      check("illegal_valid", 64'(rsp_valid), 64'd1);
      check("illegal_res", 64'(rsp_res), 64'h0);
      send(1, ALU_OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1);
      check("and_valid", 64'(rsp_valid), 64'd1);
      check("and_res", 64'(rsp_res), 64'hF000_F000);

      for (int n = 0; n < 20 && sb.size() != 0; n++) cycle();
      cycle();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
